frame_reader_fsm: RTL and testbench

FRAME_READER_FSM -- requirements
Module: frame_reader_fsm

---
 rtl/frame_pkg.sv | 31 +++
 rtl/rd_latency_counter.sv | 32 +++
 rtl/frame_reader_fsm.sv | 186 ++++++++++++++++++
 tb/tb_frame_reader_fsm.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// frame_pkg: shared definitions for the frame reader.
//   ADDR_W     frame-buffer address width (15 bits, up to 32768 pixels)
//   HDR_SYNC0  first header sync byte
//   HDR_SYNC1  second header sync byte
//   rgb888_t   packed pixel {r, g, b}; r occupies bits [23:16]
//   state_t    reader FSM states
package frame_pkg;

  localparam int ADDR_W = 15;

  localparam logic [7:0] HDR_SYNC0 = 8'hA5;
  localparam logic [7:0] HDR_SYNC1 = 8'h5A;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    FETCH,
    WAIT,
    SEND_R,
    SEND_G,
    SEND_B,
    FIN
  } state_t;

endpackage

// File: rtl/rd_latency_counter.sv
// rd_latency_counter: down-counter that times the frame-buffer read latency.
//   read_clk  clock
//   reset     asynchronous active-high reset, clears the count
//   load      load LOAD_VAL (takes priority over dec)
//   dec       decrement by one, saturating at zero
//   zero      count is zero
module rd_latency_counter #(
  parameter int LOAD_VAL = 1,
  parameter int CNT_W    = 1
) (
  input  logic read_clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge read_clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= CNT_W'(LOAD_VAL);
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/frame_reader_fsm.sv
// frame_reader_fsm: reads one frame out of a frame buffer in raster order and
// streams each pixel as three bytes (R, G, B) over a valid/ready byte link.
//   read_clk      clock
//   reset         asynchronous active-high reset
//   start         begin one frame readout (sampled only while idle)
//   read_address  frame-buffer read address
//   output_q      frame-buffer read data {R,G,B}, RD_LATENCY cycles after address
//   tx_data       byte to the transmitter
//   tx_valid      tx_data valid, held until tx_ready
//   tx_ready      transmitter accepts on tx_valid && tx_ready
//   busy          high whenever not idle
//   done          one-cycle pulse after the last byte of a frame is accepted
// Build option: define FRAME_READER_HEADER_EN to prefix every frame with the
// 4-byte header A5, 5A, FRAME_W[7:0], FRAME_H[7:0].
module frame_reader_fsm
  import frame_pkg::*;
#(
  parameter int FRAME_W    = 160,
  parameter int FRAME_H    = 120,
  parameter int RD_LATENCY = 2
) (
  input  logic              read_clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] read_address,
  input  logic [23:0]       output_q,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam int TOTAL = FRAME_W * FRAME_H;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TOTAL - 1);
  localparam int CNT_W = $clog2(RD_LATENCY + 1);

  generate
    if ((TOTAL > 32768) || (TOTAL < 1)) begin : g_bad_frame
      $error("frame_reader_fsm: FRAME_W*FRAME_H must be in 1..32768");
    end
    if (RD_LATENCY < 1) begin : g_bad_latency
      $error("frame_reader_fsm: RD_LATENCY must be at least 1");
    end
  endgenerate

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] index_reg, index_next;
  rgb888_t           pixel_reg, pixel_next;
  logic              cnt_load, cnt_dec, cnt_zero;
`ifdef FRAME_READER_HEADER_EN
  logic [1:0]        hdr_idx_reg, hdr_idx_next;
`endif

  // The index counter addresses the buffer directly, so the address is
  // already valid during FETCH and the read latency is counted from there.
  assign read_address = index_reg;

  // Loaded with RD_LATENCY-1 in FETCH: zero then marks the last of the
  // RD_LATENCY wait cycles, the cycle in which output_q holds this pixel.
  rd_latency_counter #(
    .LOAD_VAL (RD_LATENCY - 1),
    .CNT_W    (CNT_W)
  ) u_lat (
    .read_clk (read_clk),
    .reset    (reset),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge read_clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      index_reg   <= '0;
      pixel_reg   <= '0;
`ifdef FRAME_READER_HEADER_EN
      hdr_idx_reg <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      index_reg   <= index_next;
      pixel_reg   <= pixel_next;
`ifdef FRAME_READER_HEADER_EN
      hdr_idx_reg <= hdr_idx_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    index_next = index_reg;
    pixel_next = pixel_reg;
`ifdef FRAME_READER_HEADER_EN
    hdr_idx_next = hdr_idx_reg;
`endif
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    busy     = (state_reg != IDLE);
    done     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          index_next = '0;
`ifdef FRAME_READER_HEADER_EN
          hdr_idx_next = '0;
          state_next   = HDR;
`else
          state_next = FETCH;
`endif
        end
      end

      HDR: begin
`ifdef FRAME_READER_HEADER_EN
        tx_valid = 1'b1;
        case (hdr_idx_reg)
          2'd0:    tx_data = HDR_SYNC0;
          2'd1:    tx_data = HDR_SYNC1;
          2'd2:    tx_data = 8'(FRAME_W);
          default: tx_data = 8'(FRAME_H);
        endcase
        if (tx_ready) begin
          if (hdr_idx_reg == 2'd3) begin
            state_next = FETCH;
          end else begin
            hdr_idx_next = hdr_idx_reg + 2'd1;
          end
        end
`else
        state_next = IDLE;
`endif
      end

      FETCH: begin
        cnt_load   = 1'b1;
        state_next = WAIT;
      end

      WAIT: begin
        if (cnt_zero) begin
          pixel_next = rgb888_t'(output_q);
          state_next = SEND_R;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      SEND_R: begin
        tx_valid = 1'b1;
        tx_data  = pixel_reg.r;
        if (tx_ready) state_next = SEND_G;
      end

      SEND_G: begin
        tx_valid = 1'b1;
        tx_data  = pixel_reg.g;
        if (tx_ready) state_next = SEND_B;
      end

      SEND_B: begin
        tx_valid = 1'b1;
        tx_data  = pixel_reg.b;
        if (tx_ready) begin
          if (index_reg < LAST_IDX) begin
            index_next = index_reg + ADDR_W'(1);
            state_next = FETCH;
          end else begin
            state_next = FIN;
          end
        end
      end

      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_frame_reader_fsm.sv
// tb_frame_reader_fsm: table of frame scenarios plus reset-mid-frame sequence,
// all byte traffic scored against a raster-order reference of the frame.
module tb_frame_reader_fsm;

  localparam int W    = 5;
  localparam int H    = 3;
  localparam int LAT  = 2;
  localparam int NPIX = W * H;
`ifdef FRAME_READER_HEADER_EN
  localparam int HDR_BYTES = 4;
`else
  localparam int HDR_BYTES = 0;
`endif
  localparam int FB = HDR_BYTES + 3 * NPIX;
  localparam int BUDGET = 20000;

  logic        read_clk = 1'b0;
  logic        reset    = 1'b1;
  logic        start    = 1'b0;
  logic        tx_ready = 1'b0;
  logic [14:0] read_address;
  logic [23:0] output_q;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;
  int ready_pct = 100;
  int byte_k;
  int done_cnt;
  bit expect_done;
  bit prev_stall;
  logic [7:0] prev_data;

  always #5 read_clk = ~read_clk;

  frame_reader_fsm #(
    .FRAME_W    (W),
    .FRAME_H    (H),
    .RD_LATENCY (LAT)
  ) dut (
    .read_clk     (read_clk),
    .reset        (reset),
    .start        (start),
    .read_address (read_address),
    .output_q     (output_q),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .done         (done)
  );

  // Frame-buffer contents: every byte depends on the address differently.
  function automatic logic [23:0] ram_word(input int a);
    logic [7:0] r, g, b;
    r = 8'(a * 7 + 3);
    g = 8'(a) ^ 8'hC3;
    b = 8'(a);
    return {r, g, b};
  endfunction

  // Expected k-th byte of a frame: optional header then R,G,B per pixel.
  function automatic logic [7:0] exp_byte(input int k);
    int p, c, kk;
    logic [23:0] w;
    kk = k;
`ifdef FRAME_READER_HEADER_EN
    if (kk < 4) begin
      case (kk)
        0:       return 8'hA5;
        1:       return 8'h5A;
        2:       return 8'(W);
        default: return 8'(H);
      endcase
    end
    kk = kk - 4;
`endif
    p = kk / 3;
    c = kk % 3;
    w = ram_word(p);
    case (c)
      0:       return w[23:16];
      1:       return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  // Read port with LAT cycles of latency.
  logic [23:0] q_pipe [LAT];
  always @(posedge read_clk) begin
    q_pipe[0] <= ram_word(int'(read_address));
    for (int i = 1; i < LAT; i++) q_pipe[i] <= q_pipe[i-1];
  end
  assign output_q = q_pipe[LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Backpressure source.
  initial begin
    forever begin
      @(posedge read_clk);
      #1;
      tx_ready = ($urandom_range(99) < ready_pct);
    end
  end

  // Byte scoreboard and handshake/done monitor.
  initial begin
    byte_k = 0; done_cnt = 0; expect_done = 0; prev_stall = 0; prev_data = '0;
    forever begin
      @(negedge read_clk);
      if (reset) begin
        byte_k = 0; expect_done = 0; prev_stall = 0;
      end else begin
        if (expect_done) begin
          chk("done_after_last", done, 1'b1);
          if (done) done_cnt++;
          expect_done = 0;
        end else if (done) begin
          chk("done_spurious", done, 1'b0);
        end
        if (prev_stall) begin
          chk("stall_valid", tx_valid, 1'b1);
          chk("stall_data", tx_data, prev_data);
        end
        if (tx_valid && tx_ready) begin
          chk($sformatf("byte%0d", byte_k % FB), tx_data, exp_byte(byte_k % FB));
          byte_k++;
          if (byte_k % FB == 0) expect_done = 1;
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
      end
    end
  end

  typedef struct {
    int pct;
    int n_frames;
    bit hold;
    bit noise;
    int exp_bytes;
    int exp_done;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int b0, d0, cyc;
    vecs[0] = '{100, 1, 1'b0, 1'b0, FB,     1};
    vecs[1] = '{30,  1, 1'b0, 1'b0, FB,     1};
    vecs[2] = '{30,  1, 1'b0, 1'b1, FB,     1};
    vecs[3] = '{100, 3, 1'b1, 1'b0, 3 * FB, 3};
    vecs[4] = '{70,  2, 1'b1, 1'b0, 2 * FB, 2};
    vecs[5] = '{100, 1, 1'b0, 1'b1, FB,     1};

    repeat (3) @(posedge read_clk);
    #1;
    chk("rst_addr",  read_address, 15'd0);
    chk("rst_valid", tx_valid, 1'b0);
    chk("rst_data",  tx_data, 8'd0);
    chk("rst_busy",  busy, 1'b0);
    chk("rst_done",  done, 1'b0);
    @(posedge read_clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge read_clk);
    #1;

    for (int v = 0; v < 6; v++) begin
      ready_pct = vecs[v].pct;
      b0 = byte_k;
      d0 = done_cnt;
      start = 1'b1;
      @(posedge read_clk);
      #1;
      if (!vecs[v].hold) start = 1'b0;
      chk($sformatf("v%0d_busy", v), busy, 1'b1);
      cyc = 0;
      while (done_cnt < d0 + vecs[v].n_frames && cyc < BUDGET) begin
        @(posedge read_clk);
        #1;
        cyc++;
        if (vecs[v].noise) start = busy && ($urandom_range(1) == 1);
      end
      start = 1'b0;
      if (cyc >= BUDGET) chk($sformatf("v%0d_timeout", v), cyc, 0);
      repeat (15) @(posedge read_clk);
      #1;
      chk($sformatf("v%0d_bytes", v), byte_k - b0, vecs[v].exp_bytes);
      chk($sformatf("v%0d_frames", v), done_cnt - d0, vecs[v].exp_done);
      chk($sformatf("v%0d_idle", v), busy, 1'b0);
      $display("[TB] vector %0d pct=%0d frames=%0d bytes=%0d", v, vecs[v].pct,
               done_cnt - d0, byte_k - b0);
    end

    // Reset in the middle of a frame, then a clean frame from address 0.
    ready_pct = 60;
    d0 = done_cnt;
    b0 = byte_k;
    start = 1'b1;
    @(posedge read_clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while (byte_k - b0 < 20 && cyc < BUDGET) begin
      @(posedge read_clk);
      #1;
      cyc++;
    end
    if (cyc >= BUDGET) chk("midrst_timeout", cyc, 0);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_addr",  read_address, 15'd0);
    chk("midrst_valid", tx_valid, 1'b0);
    chk("midrst_data",  tx_data, 8'd0);
    chk("midrst_busy",  busy, 1'b0);
    chk("midrst_done",  done, 1'b0);
    @(posedge read_clk);
    #1;
    reset = 1'b0;
    chk("midrst_no_done", done_cnt - d0, 0);
    $display("[TB] reset mid-frame after %0d bytes", 20);

    ready_pct = 100;
    @(posedge read_clk);
    #1;
    b0 = byte_k;
    d0 = done_cnt;
    start = 1'b1;
    @(posedge read_clk);
    #1;
    start = 1'b0;
    chk("post_rst_addr0", read_address, 15'd0);
    cyc = 0;
    while (done_cnt < d0 + 1 && cyc < BUDGET) begin
      @(posedge read_clk);
      #1;
      cyc++;
    end
    if (cyc >= BUDGET) chk("post_rst_timeout", cyc, 0);
    repeat (10) @(posedge read_clk);
    #1;
    chk("post_rst_bytes", byte_k - b0, FB);
    chk("post_rst_frames", done_cnt - d0, 1);
    $display("[TB] post-reset frame bytes=%0d", byte_k - b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
